// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
// Optional per-channel load counters are enabled with DEMUX_STATS_EN.
package demux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// One-entry output register slot with valid/ready drain; optional load counter
// (DEMUX_STATS_EN).
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready_in,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_t      r_state;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain    = (r_state == SLOT_FULL) & ready_in;
  // A full slot can take a new beat in the same cycle it is being drained.
  assign can_accept = (r_state == SLOT_EMPTY) | w_drain;
  assign valid      = (r_state == SLOT_FULL);
  assign data       = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (load) begin
      r_state <= SLOT_FULL;
      r_data  <= load_data;
    end else if (w_drain) begin
      r_state <= SLOT_EMPTY;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;
`endif

endmodule : demux_out_slot

// File: rtl/demux_1to2_stream.sv
// Registered 1:2 valid/ready demultiplexer: each beat is steered to out0 or out1 by in_sel.
// Defining DEMUX_STATS_EN adds per-channel load counters cnt0/cnt1.
module demux_1to2_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic w_can0;
  logic w_can1;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // in_ready depends only on in_sel and the selected slot, never on in_valid.
  assign in_ready = rst_n & ((in_sel == CH1) ? w_can1 : w_can0);
  assign w_accept = in_valid & in_ready;
  assign w_load0  = w_accept & (in_sel == CH0);
  assign w_load1  = w_accept & (in_sel == CH1);

  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load0),
    .load_data  (in_data),
    .ready_in   (out0_ready),
    .valid      (out0_valid),
    .data       (out0_data),
    .can_accept (w_can0)
`ifdef DEMUX_STATS_EN
    ,
    .cnt        (cnt0)
`endif
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load1),
    .load_data  (in_data),
    .ready_in   (out1_ready),
    .valid      (out1_valid),
    .data       (out1_data),
    .can_accept (w_can1)
`ifdef DEMUX_STATS_EN
    ,
    .cnt        (cnt1)
`endif
  );

endmodule : demux_1to2_stream

// File: tb/tb_demux_1to2_stream.sv
// Directed self-checking bench for demux_1to2_stream (also covers DEMUX_STATS_EN when defined).
module tb_demux_1to2_stream;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
`ifdef DEMUX_STATS_EN
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  demux_1to2_stream #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    step();
    step();
    chk("rst_out0_valid", 32'(out0_valid), 32'h0);
    chk("rst_out1_valid", 32'(out1_valid), 32'h0);
    chk("rst_out0_data",  32'(out0_data),  32'h0);
    chk("rst_in_ready",   32'(in_ready),   32'h0);
    rst_n = 1'b1;
    step();

    // Route: A5 to ch0, then 3C to ch1
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 8'hA5;
    #1 chk("route_rdy0", 32'(in_ready), 32'h1);
    step();
    chk("route_o0_valid", 32'(out0_valid), 32'h1);
    chk("route_o0_data",  32'(out0_data),  32'hA5);
    chk("route_o1_idle",  32'(out1_valid), 32'h0);
    in_sel  = 1'b1;
    in_data = 8'h3C;
    #1 chk("route_rdy1", 32'(in_ready), 32'h1);
    step();
    chk("route_o1_valid", 32'(out1_valid), 32'h1);
    chk("route_o1_data",  32'(out1_data),  32'h3C);
    chk("route_o0_drain", 32'(out0_valid), 32'h0);
    chk("route_o0_hold",  32'(out0_data),  32'hA5);
    in_valid = 1'b0;
    step();
    chk("route_o1_drain", 32'(out1_valid), 32'h0);

    // Stall on ch0
    out0_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 8'h01;
    step();
    chk("stall_first_valid", 32'(out0_valid), 32'h1);
    chk("stall_first_data",  32'(out0_data),  32'h01);
    in_data = 8'h02;
    #1 chk("stall_rdy_low", 32'(in_ready), 32'h0);
    step();
    chk("stall_hold_data", 32'(out0_data), 32'h01);
    out0_ready = 1'b1;
    #1 chk("stall_rdy_release", 32'(in_ready), 32'h1);
    step();
    chk("stall_second_valid", 32'(out0_valid), 32'h1);
    chk("stall_second_data",  32'(out0_data),  32'h02);
    in_valid = 1'b0;
    step();
    chk("stall_drained", 32'(out0_valid), 32'h0);

    // Bypass a stalled ch0 through ch1
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 8'h77;
    step();
    chk("byp_o0_full", 32'(out0_valid), 32'h1);
    in_sel  = 1'b1;
    in_data = 8'h11;
    #1 chk("byp_rdy_ch1", 32'(in_ready), 32'h1);
    step();
    chk("byp_o1_valid", 32'(out1_valid), 32'h1);
    chk("byp_o1_data",  32'(out1_data),  32'h11);
    chk("byp_o0_data",  32'(out0_data),  32'h77);
    chk("byp_o0_valid", 32'(out0_valid), 32'h1);
    in_valid = 1'b0;
    in_sel   = 1'b0;
    #1 chk("byp_rdy_ch0_full", 32'(in_ready), 32'h0);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    chk("byp_o0_empty", 32'(out0_valid), 32'h0);
    chk("byp_o1_empty", 32'(out1_valid), 32'h0);

    // Back-to-back 16 beats on ch0
    in_valid = 1'b1;
    in_sel   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'h40 + 8'(i);
      #1 chk("b2b_rdy", 32'(in_ready), 32'h1);
      step();
      chk("b2b_valid", 32'(out0_valid), 32'h1);
      chk("b2b_data",  32'(out0_data),  32'h40 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end", 32'(out0_valid), 32'h0);

    // Reset mid-stream with both slots full
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 8'h5A;
    step();
    in_sel  = 1'b1;
    in_data = 8'h6B;
    step();
    chk("mid_o0_full", 32'(out0_valid), 32'h1);
    chk("mid_o1_full", 32'(out1_valid), 32'h1);
    in_sel = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_o0_valid", 32'(out0_valid), 32'h0);
    chk("mid_rst_o1_valid", 32'(out1_valid), 32'h0);
    chk("mid_rst_o0_data",  32'(out0_data),  32'h0);
    chk("mid_rst_o1_data",  32'(out1_data),  32'h0);
    chk("mid_rst_in_ready", 32'(in_ready),   32'h0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("mid_post_valid", 32'(out0_valid), 32'h0);

`ifdef DEMUX_STATS_EN
    chk("cnt_reset0", 32'(cnt0), 32'h0);
    chk("cnt_reset1", 32'(cnt1), 32'h0);
    out1_ready = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cnt1_wrap", 32'(cnt1), 32'h1);
    chk("cnt0_zero", 32'(cnt0), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_demux_1to2_stream
